branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumer/resolver end of the branch predictor interface.
- Queues each IF-stage prediction, and later matches it against the ID-stage resolution for that branch.
- Emits a one-cycle redirect plus a multi-cycle pipeline flush on mispredict.
- Emits a training update for the predictor on every resolved branch.

Parameters:
- N, 32: address/data width; the build value comes from `N in parameters.vh.
- QDEPTH, 4: in-flight prediction queue depth; power of 2, at least 2.
- FLUSH_CYCLES, 2: number of cycles o_flush stays high after a mispredict; at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_pred_valid  in  1  prediction record presented.
- i_pred_pc  in  N  PC of the predicted branch.
- i_pred_taken  in  1  predicted direction.
- i_pred_target  in  N  predicted target.
- o_pred_ready  out  1  queue accepts a record this cycle.
- i_res_valid  in  1  branch resolved in ID this cycle.
- i_res_pc  in  N  PC of the resolved branch.
- i_res_taken  in  1  actual direction.
- i_res_target  in  N  actual taken target.
- o_redirect  out  1  one-cycle fetch redirect pulse.
- o_redirect_pc  out  N  correct next PC.
- o_flush  out  1  kill younger instructions in IF/ID.
- o_upd_valid  out  1  predictor training pulse.
- o_upd_pc  out  N  branch PC to train.
- o_upd_taken  out  1  actual direction.
- o_upd_target  out  N  actual target.
- o_qerr  out  1  pulse: resolution PC disagrees with the queue head.
- o_stat_total  out  32  resolved-branch count.
- o_stat_mispred  out  32  mispredict count.

Behaviour:
- Reset: queue empty, FSM in IDLE, every output 0 (including o_redirect_pc and o_upd_*). Reset asserted mid-flush aborts the flush and returns to IDLE next cycle.
- FSM has two states: IDLE and FLUSH.
- o_pred_ready = (state==IDLE) && (count<QDEPTH). There is no full-bypass, so a full queue with a same-cycle pop still reports not-ready.
- Push: occurs when i_pred_valid && o_pred_ready.
- Pop and push in the same cycle are allowed; count is unchanged.
- Resolution in IDLE with i_res_valid falls into one of three cases:
  - Queue empty (unpredicted branch): treat as predicted not-taken; nothing is popped.
  - Head PC == i_res_pc: pop the head and compare against it.
  - Queue non-empty, head PC != i_res_pc: pulse o_qerr and force a mispredict.
- Mispredict is true when any of the following holds:
  - i_res_taken != predicted taken;
  - both predicted and actual are taken, but i_res_target != predicted target;
  - o_qerr is asserted.
- Outputs are registered with 1-cycle latency from i_res_valid:
  - o_upd_valid pulses for every resolution, with o_upd_pc/o_upd_taken/o_upd_target = i_res_*.
  - On mispredict, o_redirect pulses with o_redirect_pc = i_res_taken ? i_res_target : i_res_pc+4. The +4 wraps modulo 2^N.
- Mispredict effects:
  - Queue cleared; a push in the same cycle is dropped.
  - IDLE -> FLUSH.
  - o_flush is high for exactly FLUSH_CYCLES cycles, the first coinciding with o_redirect.
- In FLUSH: i_res_valid and i_pred_valid are ignored and o_pred_ready=0. After FLUSH_CYCLES the FSM returns to IDLE; back-to-back flushes are never merged.
- No mispredict: no redirect, no flush, state stays IDLE.
- Counter widths: queue count is log2(QDEPTH)+1 bits; pointers wrap modulo QDEPTH.

Optional Feature:
- Macro: BR_STATS_EN.
- Defined:
  - o_stat_total increments once per accepted resolution.
  - o_stat_mispred increments once per mispredict.
  - Both saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- parameters.vh holds `N, the FSM state encodings (IDLE=1'b0, FLUSH=1'b1), and the prediction record field widths.
- One sub-module, br_pred_fifo: a QDEPTH x (N+1+N) synchronous FIFO with push/pop/clear, count, full and empty.
- Compare logic, FSM and stats stay in branch_resolver.

Test Plan:
- Correct taken prediction:
  - Stimulus: push (pc=0x100, T, 0x200), then resolve (0x100, T, 0x200).
  - Response: o_upd_valid=1 one cycle later; o_redirect=0; o_flush=0; count back to 0.
- Direction mispredict:
  - Stimulus: push (0x104, T, 0x300), then resolve (0x104, NT).
  - Response: o_redirect=1 with o_redirect_pc=0x108; o_flush high for 2 cycles; o_pred_ready=0 during the flush; queue empty afterwards.
- Target mispredict:
  - Stimulus: push (0x110, T, 0x400), then resolve (0x110, T, 0x480).
  - Response: redirect to 0x480.
  - With BR_STATS_EN: o_stat_mispred=1 and o_stat_total=1.
- Full queue and same-cycle mispredict:
  - Stimulus: 4 pushes; then a 5th push offered while the head resolves as a mispredict.
  - Response: ready=0 throughout; 5th push dropped; queue cleared; count=0.
- Empty-queue and PC-mismatch cases:
  - Resolve 0x500 taken to 0x600 with an empty queue -> redirect to 0x600, o_qerr=0.
  - Head 0x10, resolve 0x20 NT -> o_qerr=1, redirect to 0x24.
- Reset during flush:
  - Stimulus: assert rst in the 1st flush cycle.
  - Response: next cycle all outputs are 0, state IDLE, o_pred_ready=1.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: default widths, FSM encoding,
// and the layout of a queued prediction record {pc, taken, target}.
package branch_resolver_pkg;

  localparam int BR_N       = 32;
  localparam int BR_TAKEN_W = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  function automatic int rec_width(input int n);
    return n + BR_TAKEN_W + n;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Prediction / resolution / redirect / training bundle between the fetch-decode
// pipeline (master) and the branch resolver (slave).
interface branch_resolver_if
  import branch_resolver_pkg::*;
#(
  parameter int N = BR_N
);

  logic         i_pred_valid;
  logic [N-1:0] i_pred_pc;
  logic         i_pred_taken;
  logic [N-1:0] i_pred_target;
  logic         o_pred_ready;

  logic         i_res_valid;
  logic [N-1:0] i_res_pc;
  logic         i_res_taken;
  logic [N-1:0] i_res_target;

  logic         o_redirect;
  logic [N-1:0] o_redirect_pc;
  logic         o_flush;

  logic         o_upd_valid;
  logic [N-1:0] o_upd_pc;
  logic         o_upd_taken;
  logic [N-1:0] o_upd_target;

  logic         o_qerr;
  logic [31:0]  o_stat_total;
  logic [31:0]  o_stat_mispred;

  modport master (
    output i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target,
    output i_res_valid, i_res_pc, i_res_taken, i_res_target,
    input  o_pred_ready, o_redirect, o_redirect_pc, o_flush,
    input  o_upd_valid, o_upd_pc, o_upd_taken, o_upd_target,
    input  o_qerr, o_stat_total, o_stat_mispred
  );

  modport slave (
    input  i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target,
    input  i_res_valid, i_res_pc, i_res_taken, i_res_target,
    output o_pred_ready, o_redirect, o_redirect_pc, o_flush,
    output o_upd_valid, o_upd_pc, o_upd_taken, o_upd_target,
    output o_qerr, o_stat_total, o_stat_mispred
  );

endinterface

// File: rtl/br_pred_fifo.sv
// In-flight prediction queue: DEPTH x W synchronous FIFO with push, pop and a
// clear that wins over a same-cycle push/pop.
module br_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is not reset; entries are only read while count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/branch_resolver.sv
// Matches ID-stage resolutions against queued IF predictions, issuing redirect,
// flush and predictor training. Optional counters under `BR_STATS_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int N            = BR_N,
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bus
);

  localparam int CW  = $clog2(QDEPTH) + 1;
  localparam int RW  = rec_width(N);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e      state_q, state_d;
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;

  logic [RW-1:0]  head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty, unused_fifo_full;
  logic           fifo_push, fifo_pop;

  logic [N-1:0]   head_pc, head_target;
  logic           head_taken;
  logic           pred_ready, res_fire, head_match, qerr, pred_taken, mispredict;
  logic [N-1:0]   redirect_pc_d;

  logic           upd_valid_q, upd_taken_q, redirect_q, qerr_q;
  logic [N-1:0]   upd_pc_q, upd_target_q, redirect_pc_q;

  assign head_pc     = head[RW-1 -: N];
  assign head_taken  = head[N];
  assign head_target = head[N-1:0];

  assign pred_ready = (state_q == ST_IDLE) && (fifo_count < CW'(QDEPTH));
  assign res_fire   = (state_q == ST_IDLE) && bus.i_res_valid;
  assign head_match = !fifo_empty && (head_pc == bus.i_res_pc);
  assign qerr       = res_fire && !fifo_empty && !head_match;
  // An unpredicted branch (empty queue) counts as predicted not-taken.
  assign pred_taken = !fifo_empty && head_taken;
  assign mispredict = res_fire && (qerr || (bus.i_res_taken != pred_taken) ||
                      (bus.i_res_taken && pred_taken && (bus.i_res_target != head_target)));

  assign fifo_push = bus.i_pred_valid && pred_ready && !mispredict;
  assign fifo_pop  = res_fire && head_match;

  assign redirect_pc_d = bus.i_res_taken ? bus.i_res_target : bus.i_res_pc + N'(4);

  br_pred_fifo #(
    .DEPTH (QDEPTH),
    .W     (RW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (mispredict),
    .din_i   ({bus.i_pred_pc, bus.i_pred_taken, bus.i_pred_target}),
    .dout_o  (head),
    .count_o (fifo_count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_IDLE;
        else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Payloads are zeroed when their valid is low so idle outputs read as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      qerr_q        <= 1'b0;
    end else begin
      upd_valid_q   <= res_fire;
      upd_pc_q      <= res_fire ? bus.i_res_pc : '0;
      upd_taken_q   <= res_fire && bus.i_res_taken;
      upd_target_q  <= res_fire ? bus.i_res_target : '0;
      redirect_q    <= mispredict;
      redirect_pc_q <= mispredict ? redirect_pc_d : '0;
      qerr_q        <= qerr;
    end
  end

  assign bus.o_pred_ready  = pred_ready;
  assign bus.o_flush       = (state_q == ST_FLUSH);
  assign bus.o_redirect    = redirect_q;
  assign bus.o_redirect_pc = redirect_pc_q;
  assign bus.o_upd_valid   = upd_valid_q;
  assign bus.o_upd_pc      = upd_pc_q;
  assign bus.o_upd_taken   = upd_taken_q;
  assign bus.o_upd_target  = upd_target_q;
  assign bus.o_qerr        = qerr_q;

`ifdef BR_STATS_EN
  logic [31:0] stat_total_q, stat_mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total_q   <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (res_fire && (stat_total_q != '1))     stat_total_q   <= stat_total_q + 1'b1;
      if (mispredict && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 1'b1;
    end
  end

  assign bus.o_stat_total   = stat_total_q;
  assign bus.o_stat_mispred = stat_mispred_q;
`else
  assign bus.o_stat_total   = '0;
  assign bus.o_stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver: a queue-based reference model predicts
// every registered output, plus the directed scenarios from the test plan.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  localparam int N  = 32;
  localparam int QD = 4;
  localparam int FC = 2;

  typedef struct {
    logic [N-1:0] pc;
    logic         taken;
    logic [N-1:0] tgt;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolver_if #(.N(N)) bus();

  branch_resolver #(
    .N            (N),
    .QDEPTH       (QD),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  rec_t         mq[$];
  int           flush_left;
  logic         e_upd_valid, e_upd_taken, e_redir, e_qerr;
  logic [N-1:0] e_upd_pc, e_upd_tgt, e_redir_pc;
  logic [31:0]  m_total, m_mis;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [N-1:0] ppc, input logic pt, input logic [N-1:0] ptg,
                       input logic rv, input logic [N-1:0] rpc, input logic rt, input logic [N-1:0] rtg);
    bus.i_pred_valid  = pv;
    bus.i_pred_pc     = ppc;
    bus.i_pred_taken  = pt;
    bus.i_pred_target = ptg;
    bus.i_res_valid   = rv;
    bus.i_res_pc      = rpc;
    bus.i_res_taken   = rt;
    bus.i_res_target  = rtg;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic push(input logic [N-1:0] pc, input logic t, input logic [N-1:0] tg);
    drive(1'b1, pc, t, tg, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic resolve(input logic [N-1:0] pc, input logic t, input logic [N-1:0] tg);
    drive(1'b0, '0, 1'b0, '0, 1'b1, pc, t, tg);
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic ready, mis, pt;
    logic [N-1:0] ptgt;
    ready = (flush_left == 0) && (mq.size() < QD);
    e_upd_valid = 1'b0; e_upd_pc = '0; e_upd_taken = 1'b0; e_upd_tgt = '0;
    e_redir = 1'b0; e_redir_pc = '0; e_qerr = 1'b0;
    if (rst) begin
      mq.delete();
      flush_left = 0;
      m_total = 0;
      m_mis = 0;
      return;
    end
    if (flush_left > 0) begin
      flush_left--;
      return;
    end
    mis = 1'b0;
    if (bus.i_res_valid) begin
      e_upd_valid = 1'b1;
      e_upd_pc    = bus.i_res_pc;
      e_upd_taken = bus.i_res_taken;
      e_upd_tgt   = bus.i_res_target;
      if (mq.size() == 0) begin
        mis = bus.i_res_taken;
      end else if (mq[0].pc == bus.i_res_pc) begin
        pt   = mq[0].taken;
        ptgt = mq[0].tgt;
        void'(mq.pop_front());
        mis = (bus.i_res_taken != pt) || (bus.i_res_taken && pt && bus.i_res_target != ptgt);
      end else begin
        e_qerr = 1'b1;
        mis = 1'b1;
      end
      if (m_total != 32'hFFFF_FFFF) m_total++;
      if (mis && m_mis != 32'hFFFF_FFFF) m_mis++;
    end
    if (mis) begin
      e_redir    = 1'b1;
      e_redir_pc = bus.i_res_taken ? bus.i_res_target : bus.i_res_pc + 32'd4;
      mq.delete();
      flush_left = FC;
    end else if (bus.i_pred_valid && ready) begin
      mq.push_back('{pc: bus.i_pred_pc, taken: bus.i_pred_taken, tgt: bus.i_pred_target});
    end
  endtask

  task automatic step();
    check("ready", bus.o_pred_ready, (flush_left == 0) && (mq.size() < QD));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("upd_valid", bus.o_upd_valid, e_upd_valid);
    if (e_upd_valid) begin
      check("upd_pc", bus.o_upd_pc, e_upd_pc);
      check("upd_taken", bus.o_upd_taken, e_upd_taken);
      check("upd_target", bus.o_upd_target, e_upd_tgt);
    end
    check("redirect", bus.o_redirect, e_redir);
    if (e_redir) check("redirect_pc", bus.o_redirect_pc, e_redir_pc);
    check("qerr", bus.o_qerr, e_qerr);
    check("flush", bus.o_flush, flush_left > 0);
`ifdef BR_STATS_EN
    check("stat_total", bus.o_stat_total, m_total);
    check("stat_mispred", bus.o_stat_mispred, m_mis);
`else
    check("stat_total", bus.o_stat_total, 32'd0);
    check("stat_mispred", bus.o_stat_mispred, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_redir"}, bus.o_redirect, 1'b0);
    check({tag, "_redir_pc"}, bus.o_redirect_pc, '0);
    check({tag, "_flush"}, bus.o_flush, 1'b0);
    check({tag, "_upd_valid"}, bus.o_upd_valid, 1'b0);
    check({tag, "_upd_pc"}, bus.o_upd_pc, '0);
    check({tag, "_upd_taken"}, bus.o_upd_taken, 1'b0);
    check({tag, "_upd_target"}, bus.o_upd_target, '0);
    check({tag, "_qerr"}, bus.o_qerr, 1'b0);
    check({tag, "_stat_total"}, bus.o_stat_total, 32'd0);
    check({tag, "_ready"}, bus.o_pred_ready, 1'b1);
  endtask

  initial begin
    logic [N-1:0] next_pc, rpc;
    flush_left = 0;
    m_total = 0;
    m_mis = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // Correct taken prediction
    push(32'h100, 1'b1, 32'h200); step();
    resolve(32'h100, 1'b1, 32'h200); step();
    check("t_ok_upd", bus.o_upd_valid, 1'b1);
    check("t_ok_redir", bus.o_redirect, 1'b0);
    check("t_ok_flush", bus.o_flush, 1'b0);
    idle(); step();

    // Direction mispredict
    push(32'h104, 1'b1, 32'h300); step();
    resolve(32'h104, 1'b0, 32'h0); step();
    check("dir_redir", bus.o_redirect, 1'b1);
    check("dir_redir_pc", bus.o_redirect_pc, 32'h108);
    check("dir_flush1", bus.o_flush, 1'b1);
    check("dir_ready1", bus.o_pred_ready, 1'b0);
    idle(); step();
    check("dir_flush2", bus.o_flush, 1'b1);
    check("dir_ready2", bus.o_pred_ready, 1'b0);
    check("dir_redir_once", bus.o_redirect, 1'b0);
    step();
    check("dir_flush_end", bus.o_flush, 1'b0);
    check("dir_ready_end", bus.o_pred_ready, 1'b1);

    // Target mispredict from a fresh reset so the counters are exact
    do_reset();
    push(32'h110, 1'b1, 32'h400); step();
    resolve(32'h110, 1'b1, 32'h480); step();
    check("tgt_redir_pc", bus.o_redirect_pc, 32'h480);
`ifdef BR_STATS_EN
    check("tgt_stat_mispred", bus.o_stat_mispred, 32'd1);
    check("tgt_stat_total", bus.o_stat_total, 32'd1);
`endif
    idle(); step(); step();

    // Full queue, then 5th push offered alongside a mispredicting resolution
    for (int i = 0; i < QD; i++) begin
      push(32'h10 + 32'(4 * i), 1'b1, 32'h900); step();
    end
    check("full_ready", bus.o_pred_ready, 1'b0);
    drive(1'b1, 32'h40, 1'b1, 32'h900, 1'b1, 32'h10, 1'b0, 32'h0);
    step();
    check("full_redir_pc", bus.o_redirect_pc, 32'h14);
    idle(); step(); step();
    check("full_cleared_ready", bus.o_pred_ready, 1'b1);
    // Queue must be empty: a resolution of the dropped push is unpredicted (not-taken, no qerr)
    resolve(32'h40, 1'b0, 32'h0); step();
    check("full_dropped_qerr", bus.o_qerr, 1'b0);
    check("full_dropped_redir", bus.o_redirect, 1'b0);

    // Unpredicted taken branch
    resolve(32'h500, 1'b1, 32'h600); step();
    check("empty_redir_pc", bus.o_redirect_pc, 32'h600);
    check("empty_qerr", bus.o_qerr, 1'b0);
    idle(); step(); step();

    // Head PC disagrees with resolution
    push(32'h10, 1'b1, 32'h50); step();
    resolve(32'h20, 1'b0, 32'h0); step();
    check("qerr_pulse", bus.o_qerr, 1'b1);
    check("qerr_redir_pc", bus.o_redirect_pc, 32'h24);
    idle(); step(); step();

    // Fall-through PC wraps at the top of the address space
    push(32'hFFFF_FFFC, 1'b1, 32'h80); step();
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0); step();
    check("wrap_redir_pc", bus.o_redirect_pc, 32'h0);
    idle(); step(); step();

    // Reset in the first flush cycle
    push(32'h104, 1'b1, 32'h300); step();
    resolve(32'h104, 1'b0, 32'h0); step();
    check("rstf_flush", bus.o_flush, 1'b1);
    do_reset();
    check_all_zero("rst_flush");

    // Randomized traffic against the model
    next_pc = 32'h8000;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (mq.size() > 0 && $urandom_range(0, 9) != 0) rpc = mq[0].pc;
      else rpc = 32'($urandom_range(0, 15)) << 2;
      drive($urandom_range(0, 1) == 1, next_pc, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000,
            $urandom_range(0, 2) == 0, rpc, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 32'h1000 : 32'h2000);
      next_pc = next_pc + 32'd4;
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
